// File: rtl/mux_pkg.sv
// mux_pkg: shared constants for the 2:1 mux datapath and its feeder.
// Select encoding and occupancy-width helper live here.
package mux_pkg;

  localparam int MUX_WIDTH = 2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mux2to1.sv
// mux2to1: the existing 2-bit 2:1 mux datapath.
// sel = SEL_A picks a, SEL_B picks b.
module mux2to1
  import mux_pkg::*;
#(
  parameter int W = MUX_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = (sel == SEL_B) ? b : a;

endmodule

// File: rtl/mux_rr_feeder.sv
// mux_rr_feeder: round-robin arbiter over two valid/ready sources that
// steers the 2:1 mux and buffers the chosen word in a small FIFO.
module mux_rr_feeder
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [WIDTH-1:0]        A,
  input  logic                    AValid,
  output logic                    AReady,
  input  logic [WIDTH-1:0]        B,
  input  logic                    BValid,
  output logic                    BReady,
  output logic                    Sel,
  output logic [WIDTH-1:0]        C,
  output logic                    CValid,
  input  logic                    CReady,
  output logic [cnt_w(DEPTH)-1:0] Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic             last_sel;
  logic             grant;
  logic             full;
  logic             push;
  logic             pop;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] mem [DEPTH];

  // Idle keeps the previous grant so the mux select never toggles
  // without a transfer.
  always_comb begin
    grant = last_sel;
    unique case (1'b1)
      (AValid && BValid):  grant = ~last_sel;
      (AValid && !BValid): grant = SEL_A;
      (!AValid && BValid): grant = SEL_B;
      default:             grant = last_sel;
    endcase
  end

  assign full   = (Count == CW'(DEPTH));
  assign Sel    = grant;
  assign AReady = (grant == SEL_A) && !full;
  assign BReady = (grant == SEL_B) && !full;

  assign push = (AValid && AReady) || (BValid && BReady);
  assign pop  = CValid && CReady;

  assign CValid = (Count != '0);
  assign C      = CValid ? mem[rptr] : '0;

  mux2to1 #(
    .W (WIDTH)
  ) u_mux (
    .a   (A),
    .b   (B),
    .sel (Sel),
    .y   (wdata)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      last_sel <= SEL_B;
      wptr     <= '0;
      rptr     <= '0;
      Count    <= '0;
    end else begin
      if (push) begin
        last_sel <= grant;
        wptr     <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: Count <= Count;
      endcase
    end
  end

  // Storage needs no reset: C is masked while the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

endmodule

// File: tb/tb_mux_rr_feeder.sv
// tb_mux_rr_feeder: directed scenarios plus random traffic checked
// against a queue-based model of the arbiter and FIFO.
module tb_mux_rr_feeder;

  localparam int W = 2;
  localparam int D = 2;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [W-1:0] A, B, C;
  logic         AValid, BValid, CReady;
  logic         AReady, BReady, Sel, CValid;
  logic [1:0]   Count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  bit           last;
  bit           acc_a, acc_b;

  mux_rr_feeder #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .A      (A),
    .AValid (AValid),
    .AReady (AReady),
    .B      (B),
    .BValid (BValid),
    .BReady (BReady),
    .Sel    (Sel),
    .C      (C),
    .CValid (CValid),
    .CReady (CReady),
    .Count  (Count)
  );

  always #5 Clk = ~Clk;

  function automatic bit g_exp();
    if (AValid && BValid) return !last;
    if (AValid) return 1'b0;
    if (BValid) return 1'b1;
    return last;
  endfunction

  function automatic bit full_exp();
    return q.size() == D;
  endfunction

  task automatic model_update();
    bit g;
    bit push;
    bit pop;
    logic [W-1:0] w;
    g     = g_exp();
    acc_a = !full_exp() && !g && AValid;
    acc_b = !full_exp() && g && BValid;
    push  = acc_a || acc_b;
    pop   = (q.size() != 0) && CReady;
    w     = g ? B : A;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(w);
      last = g;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    if (!Rst) model_update();
    #1;
  endtask

  task automatic drive(input bit av, input logic [W-1:0] a,
                       input bit bv, input logic [W-1:0] b,
                       input bit cr);
    AValid = av;
    A      = a;
    BValid = bv;
    B      = b;
    CReady = cr;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    q.delete();
    last = 1'b1;
    drive(0, 2'b00, 0, 2'b00, 0);
    @(negedge Clk);
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    q.delete();
    last = 1'b1;
    drive(0, 2'b00, 0, 2'b00, 0);
    @(negedge Clk);
    checks++;
    if ({CValid, Count, C} !== 5'b0) begin
      errors++;
      $display("FAIL reset_fifo got cv=%b cnt=%0d c=%b want 0 0 00",
               CValid, Count, C);
    end
    checks++;
    if ({Sel, AReady, BReady} !== 3'b101) begin
      errors++;
      $display("FAIL reset_grant got sel/ar/br=%b want 101",
               {Sel, AReady, BReady});
    end
    Rst = 1'b0;
    tick();
    drive(1, 2'b01, 1, 2'b11, 0);
    @(negedge Clk);
    checks++;
    if (Sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_contend got sel=%b want 0", Sel);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 2'b10, 0, 2'b00, 1);
    @(negedge Clk);
    checks++;
    if ({Sel, AReady, BReady} !== 3'b010) begin
      errors++;
      $display("FAIL single_grant got sel/ar/br=%b want 010",
               {Sel, AReady, BReady});
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if ({CValid, C, BReady} !== 4'b1100) begin
        errors++;
        $display("FAIL single_out[%0d] got cv/c/br=%b want 1100",
                 i, {CValid, C, BReady});
      end
      tick();
    end
    drive(0, 2'b00, 0, 2'b00, 1);
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic prev;
    logic [W-1:0] want;
    do_reset();
    drive(1, 2'b01, 1, 2'b11, 1);
    prev = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      checks++;
      if (Sel !== ~prev || Sel !== g_exp()) begin
        errors++;
        $display("FAIL rr_sel[%0d] got %b want %b", i, Sel, ~prev);
      end
      prev = Sel;
      if (i > 0) begin
        want = (i % 2 == 1) ? 2'b01 : 2'b11;
        checks++;
        if (CValid !== 1'b1 || C !== want) begin
          errors++;
          $display("FAIL rr_c[%0d] got cv=%b c=%b want 1 %b",
                   i, CValid, C, want);
        end
      end
      tick();
    end
    drive(0, 2'b00, 0, 2'b00, 1);
    tick();
    tick();
  endtask

  task automatic test_full();
    logic s0;
    do_reset();
    drive(1, 2'b01, 1, 2'b11, 0);
    tick();
    tick();
    @(negedge Clk);
    s0 = Sel;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge Clk);
      checks++;
      if ({Count, AReady, BReady} !== 4'b1000 || Sel !== s0) begin
        errors++;
        $display("FAIL full_hold[%0d] got cnt=%0d ar=%b br=%b sel=%b",
                 i, Count, AReady, BReady, Sel);
      end
      tick();
    end
    CReady = 1'b1;
    @(negedge Clk);
    checks++;
    if (C !== 2'b01 || AReady !== 1'b0) begin
      errors++;
      $display("FAIL full_pop got c=%b ar=%b want 01 0", C, AReady);
    end
    tick();
    CReady = 1'b0;
    @(negedge Clk);
    checks++;
    if ({Count, Sel, AReady, C} !== 6'b010111) begin
      errors++;
      $display("FAIL full_resume got cnt=%0d sel=%b ar=%b c=%b",
               Count, Sel, AReady, C);
    end
    tick();
    drive(0, 2'b00, 0, 2'b00, 1);
    tick();
    tick();
  endtask

  task automatic test_idle();
    do_reset();
    drive(1, 2'b01, 1, 2'b11, 1);
    tick();
    tick();
    drive(0, 2'b00, 0, 2'b00, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++;
      if (Sel !== 1'b1 || Count !== 2'(q.size())) begin
        errors++;
        $display("FAIL idle_hold[%0d] got sel=%b cnt=%0d want 1 %0d",
                 i, Sel, Count, q.size());
      end
      tick();
    end
    @(negedge Clk);
    checks++;
    if (Count !== 2'd0 || CValid !== 1'b0) begin
      errors++;
      $display("FAIL idle_drain got cnt=%0d cv=%b want 0 0",
               Count, CValid);
    end
    tick();
  endtask

  task automatic test_push_pop();
    logic [W-1:0] nxt;
    logic [W-1:0] want;
    do_reset();
    drive(1, 2'b10, 0, 2'b00, 0);
    tick();
    want = 2'b10;
    for (int i = 0; i < 6; i++) begin
      nxt = W'($urandom);
      drive(1, nxt, 0, 2'b00, 1);
      @(negedge Clk);
      checks++;
      if (Count !== 2'd1 || C !== want || AReady !== 1'b1) begin
        errors++;
        $display("FAIL pushpop[%0d] got cnt=%0d c=%b ar=%b want 1 %b 1",
                 i, Count, C, AReady, want);
      end
      tick();
      want = nxt;
    end
    drive(0, 2'b00, 0, 2'b00, 1);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 2'b01, 1, 2'b11, 0);
    tick();
    tick();
    @(negedge Clk);
    #2;
    Rst = 1'b1;
    q.delete();
    last = 1'b1;
    #1;
    checks++;
    if (CValid !== 1'b0 || Count !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_clear got cv=%b cnt=%0d want 0 0",
               CValid, Count);
    end
    #1;
    Rst = 1'b0;
    #0;
    checks++;
    if (Sel !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_grant got sel=%b want 0", Sel);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (CValid !== 1'b1 || C !== 2'b01 || Count !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_first got cv=%b c=%b cnt=%0d want 1 01 1",
               CValid, C, Count);
    end
    tick();
    drive(0, 2'b00, 0, 2'b00, 1);
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [5:0] want;
    do_reset();
    acc_a = 1'b0;
    acc_b = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!AValid || acc_a) begin
        AValid = ($urandom_range(0, 3) != 0);
        A      = W'($urandom);
      end
      if (!BValid || acc_b) begin
        BValid = ($urandom_range(0, 3) != 0);
        B      = W'($urandom);
      end
      CReady = ($urandom_range(0, 2) != 0);
      @(negedge Clk);
      want = {g_exp(), !full_exp() && !g_exp(), !full_exp() && g_exp(),
              q.size() != 0, 2'(q.size())};
      checks++;
      if ({Sel, AReady, BReady, CValid, Count} !== want) begin
        errors++;
        $display("FAIL rand_ctl[%0d] got %b want %b (sel ar br cv cnt)",
                 i, {Sel, AReady, BReady, CValid, Count}, want);
      end
      if (q.size() != 0) begin
        checks++;
        if (C !== q[0]) begin
          errors++;
          $display("FAIL rand_data[%0d] got c=%b want %b", i, C, q[0]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_idle();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
